// File: rtl/video_fetch_fifo_pkg.sv
// Shared defaults and FSM state encodings for the video fetch FIFO.
package video_fetch_fifo_pkg;
   localparam int DEPTH_DEF = 8;
   localparam int DW_DEF    = 16;
   localparam int FW_W      = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/video_fetch_fifo_if.sv
// DRAM-side request/return and pixel-side pop signals of the video fetch FIFO.
interface video_fetch_fifo_if #(
   parameter int DW = video_fetch_fifo_pkg::DW_DEF
);
   logic          video_go;
   logic          video_next;
   logic          video_strobe;
   logic [DW-1:0] video_data;
   logic          pop_req;
   logic [DW-1:0] pop_data;
   logic          pop_valid;

   modport slave (
      output video_go, pop_data, pop_valid,
      input  video_next, video_strobe, video_data, pop_req
   );

   modport master (
      input  video_go, pop_data, pop_valid,
      output video_next, video_strobe, video_data, pop_req
   );
endinterface

// File: rtl/video_fifo_mem.sv
// DEPTH x DW word FIFO with occupancy count, synchronous flush and registered pop output.
module video_fifo_mem
   import video_fetch_fifo_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int DW    = DW_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic [CW-1:0] count,
   output logic          empty
);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // a pop in the same cycle frees the slot, so a push on full still lands
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= mem[rd_ptr];
         end
         rd_valid <= pop_ok;
         count    <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop_ok && !flush))
      else $error("word dropped: push into full FIFO");
endmodule

// File: rtl/video_fetch_fifo.sv
// Per-line DRAM fetch sequencer feeding a small word FIFO toward the pixel serializer.
// Build option VIDEO_FETCH_STATS_EN adds underrun_cnt, a per-frame underrun event counter.
//
// state    | meaning
// ST_IDLE  | no fetch for this line (blank line, zero words, or line done)
// ST_FETCH | issuing requests while FIFO + in-flight words leave room
// ST_DRAIN | all requests issued, waiting for outstanding read data
module video_fetch_fifo
   import video_fetch_fifo_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            line_start,
   input  logic            vpix,
   input  logic [FW_W-1:0] fetch_words,
   video_fetch_fifo_if.slave bus,
   output logic            underrun
`ifdef VIDEO_FETCH_STATS_EN
   ,
   output logic [7:0]      underrun_cnt
`endif
);
   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   fetch_state_t    state, state_nxt;
   logic [FW_W-1:0] fw_q;
   logic [FW_W-1:0] issued;
   logic [CW-1:0]   inflight, inflight_nxt;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   count;
   logic            empty;
   logic            accept;
   logic            push;
   logic            pop;
   logic [DW-1:0]   rd_data;
   logic            rd_valid;

   assign bus.video_go = (state == ST_FETCH) && (({1'b0, count} + {1'b0, inflight}) < DEPTH_L);
   assign accept       = bus.video_next & bus.video_go;
   assign push         = bus.video_strobe && (discard == '0) && !line_start;
   assign pop          = bus.pop_req && !line_start;
   assign bus.pop_data = rd_data;
   assign bus.pop_valid = rd_valid;

   always_comb begin
      inflight_nxt = inflight;
      case ({accept, bus.video_strobe})
         2'b10:   if (inflight != CW'(DEPTH)) inflight_nxt = inflight + CW'(1);
         2'b01:   if (inflight != '0)         inflight_nxt = inflight - CW'(1);
         default: inflight_nxt = inflight;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (line_start) begin
         state_nxt = (vpix && fetch_words != '0) ? ST_FETCH : ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            // leave on the last grant itself so no extra request slips out
            ST_FETCH: if (accept && (issued + FW_W'(1)) == fw_q) state_nxt = ST_DRAIN;
            ST_DRAIN: if (inflight == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         fw_q     <= '0;
         issued   <= '0;
         inflight <= '0;
         discard  <= '0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (line_start) begin
            // everything still outstanding belongs to the old line
            fw_q     <= fetch_words;
            issued   <= '0;
            discard  <= inflight_nxt;
            underrun <= 1'b0;
         end else begin
            if (accept) issued <= issued + FW_W'(1);
            if (bus.video_strobe && discard != '0) discard <= discard - CW'(1);
            if (bus.pop_req && empty) underrun <= 1'b1;
         end
      end
   end

`ifdef VIDEO_FETCH_STATS_EN
   logic blank_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
         blank_seen   <= 1'b0;
      end else if (line_start) begin
         if (!vpix) begin
            blank_seen <= 1'b1;
         end else if (blank_seen) begin
            blank_seen   <= 1'b0;
            underrun_cnt <= '0;
         end
      end else if (bus.pop_req && empty && underrun_cnt != 8'hff) begin
         underrun_cnt <= underrun_cnt + 8'd1;
      end
   end
`endif

   video_fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (line_start),
      .push     (push),
      .wr_data  (bus.video_data),
      .pop      (pop),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .empty    (empty)
   );
endmodule

// File: tb/tb_video_fetch_fifo.sv
// Scenario bench for video_fetch_fifo: DRAM arbiter/return model plus popped-word scoreboard.
module tb_video_fetch_fifo;
   localparam int DEPTH = 8;
   localparam int LAT   = 4;

   typedef struct {
      int          due;
      logic [15:0] data;
      bit          old;
   } ret_t;

   logic       clk;
   logic       rst_n;
   logic       line_start;
   logic       vpix;
   logic [6:0] fetch_words;
   logic       underrun;
`ifdef VIDEO_FETCH_STATS_EN
   logic [7:0] underrun_cnt;
`endif

   video_fetch_fifo_if #(.DW(16)) bus ();

   video_fetch_fifo #(.DEPTH(DEPTH), .DW(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .line_start   (line_start),
      .vpix         (vpix),
      .fetch_words  (fetch_words),
      .bus          (bus),
      .underrun     (underrun)
`ifdef VIDEO_FETCH_STATS_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          gnt_period = 0;
   int          pop_period = 0;
   bit          pop_force = 0;
   int          tb_cnt = 0;
   int          tb_infl = 0;
   int          word_idx = 0;
   int          npop = 0;
   logic [7:0]  line_tag = 8'h10;
   logic [15:0] first_pop = '0;
   logic [15:0] last_pop = '0;
   ret_t        ret_q[$];
   logic [15:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "timeout");
   end

   // One cycle: sample outputs at negedge, then drive inputs for the next posedge.
   task automatic tick(input bit ls, input bit vp);
      bit          acc;
      bit          push_now;
      bit          pop_now;
      ret_t        r;
      logic [15:0] e;
      @(negedge clk);
      cyc++;
      if (bus.pop_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_extra: got word %h, expected no word", bus.pop_data);
         end else begin
            e = exp_q.pop_front();
            if (npop == 0) first_pop = bus.pop_data;
            last_pop = bus.pop_data;
            npop++;
            if (bus.pop_data !== e) begin
               failures++;
               $display("FAIL pop_data: got %h expected %h", bus.pop_data, e);
            end
         end
      end
      if (bus.video_go) begin
         checks++;
         if (tb_cnt + tb_infl >= DEPTH) begin
            failures++;
            $display("FAIL go_rule: video_go=1 with count+inflight=%0d, required < %0d", tb_cnt + tb_infl, DEPTH);
         end
      end
      acc = 1'b0;
      bus.video_next = 1'b0;
      if (gnt_period != 0 && (cyc % gnt_period) == 0) begin
         bus.video_next = 1'b1;
         acc = bus.video_go;
      end
      if (acc) begin
         r.due  = cyc + LAT;
         r.data = {line_tag, 8'(word_idx)};
         r.old  = ls;
         ret_q.push_back(r);
         if (!ls) begin
            exp_q.push_back(r.data);
            word_idx++;
         end
      end
      push_now = 1'b0;
      bus.video_strobe = 1'b0;
      bus.video_data   = 16'hffff;
      if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
         r = ret_q.pop_front();
         bus.video_strobe = 1'b1;
         bus.video_data   = r.data;
         push_now = !r.old && !ls;
         if (tb_infl > 0) tb_infl--;
      end
      if (acc) tb_infl++;
      bus.pop_req = (pop_period != 0 && (cyc % pop_period) == 0) || pop_force;
      pop_now = bus.pop_req && !ls && tb_cnt != 0;
      if (ls) begin
         tb_cnt = 0;
         exp_q.delete();
         foreach (ret_q[i]) ret_q[i].old = 1'b1;
         word_idx = 0;
         npop = 0;
         line_tag = line_tag + 8'd1;
      end else begin
         if (push_now) tb_cnt++;
         if (pop_now) tb_cnt--;
      end
      line_start = ls;
      vpix = vp;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.video_go !== 1'b0) begin failures++; $display("FAIL reset_go: got %b expected 0", bus.video_go); end
      checks++;
      if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid: got %b expected 0", bus.pop_valid); end
      checks++;
      if (bus.pop_data !== 16'h0) begin failures++; $display("FAIL reset_pop_data: got %h expected 0000", bus.pop_data); end
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
`ifdef VIDEO_FETCH_STATS_EN
      checks++;
      if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_underrun_cnt: got %0d expected 0", underrun_cnt); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      fetch_words = 7'd32;
      gnt_period = 2;
      pop_period = 6;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 3000 && npop < 32; i++) tick(1'b0, 1'b1);
      checks++;
      if (npop != 32) begin failures++; $display("FAIL stream_pops: got %0d words expected 32", npop); end
      repeat (10) tick(1'b0, 1'b1);
      checks++;
      if (word_idx != 32) begin failures++; $display("FAIL stream_issued: got %0d grants expected 32", word_idx); end
      checks++;
      if (bus.video_go !== 1'b0) begin failures++; $display("FAIL stream_go_end: got %b expected 0", bus.video_go); end
   endtask

   task automatic test_backpressure();
      fetch_words = 7'd20;
      gnt_period = 1;
      pop_period = 0;
      tick(1'b1, 1'b1);
      repeat (40) tick(1'b0, 1'b1);
      checks++;
      if (word_idx != DEPTH) begin failures++; $display("FAIL bp_granted: got %0d expected %0d", word_idx, DEPTH); end
      checks++;
      if (bus.video_go !== 1'b0) begin failures++; $display("FAIL bp_go_full: got %b expected 0", bus.video_go); end
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL bp_underrun: got %b expected 0", underrun); end
      pop_force = 1'b1;
      tick(1'b0, 1'b1);
      pop_force = 1'b0;
      repeat (12) tick(1'b0, 1'b1);
      checks++;
      if (npop != 1) begin failures++; $display("FAIL bp_one_pop: got %0d pops expected 1", npop); end
      checks++;
      if (word_idx != DEPTH + 1) begin failures++; $display("FAIL bp_still_fetch: got %0d grants expected %0d", word_idx, DEPTH + 1); end
      checks++;
      if (bus.video_go !== 1'b0) begin failures++; $display("FAIL bp_go_refull: got %b expected 0", bus.video_go); end
   endtask

   task automatic test_flush();
      logic [15:0] want;
      fetch_words = 7'd3;
      gnt_period = 1;
      pop_period = 0;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 20 && word_idx < 3; i++) tick(1'b0, 1'b1);
      checks++;
      if (tb_infl != 3) begin failures++; $display("FAIL flush_setup: got %0d inflight expected 3", tb_infl); end
      fetch_words = 7'd4;
      tick(1'b1, 1'b1);
      want = {line_tag, 8'h00};
      pop_period = 1;
      for (int i = 0; i < 80 && npop < 4; i++) tick(1'b0, 1'b1);
      repeat (10) tick(1'b0, 1'b1);
      checks++;
      if (npop != 4) begin failures++; $display("FAIL flush_pops: got %0d words expected 4", npop); end
      checks++;
      if (first_pop !== want) begin failures++; $display("FAIL flush_first_word: got %h expected %h", first_pop, want); end
      pop_period = 0;
      gnt_period = 0;
   endtask

   task automatic test_underrun();
      logic [15:0] held;
      held = last_pop;
      tick(1'b1, 1'b0);
      pop_force = 1'b1;
      tick(1'b0, 1'b0);
      pop_force = 1'b0;
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL ur_cleared: got %b expected 0", underrun); end
      tick(1'b0, 1'b0);
      checks++;
      if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL ur_pop_valid: got %b expected 0", bus.pop_valid); end
      checks++;
      if (underrun !== 1'b1) begin failures++; $display("FAIL ur_set: got %b expected 1", underrun); end
      checks++;
      if (bus.pop_data !== held) begin failures++; $display("FAIL ur_data_hold: got %h expected %h", bus.pop_data, held); end
      repeat (3) tick(1'b0, 1'b0);
      checks++;
      if (underrun !== 1'b1) begin failures++; $display("FAIL ur_sticky: got %b expected 1", underrun); end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL ur_line_clear: got %b expected 0", underrun); end
   endtask

   task automatic test_reset_mid();
      int go_seen;
      fetch_words = 7'd20;
      gnt_period = 1;
      pop_period = 3;
      tick(1'b1, 1'b1);
      repeat (10) tick(1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.video_go !== 1'b0) begin failures++; $display("FAIL rst_mid_go: got %b expected 0", bus.video_go); end
      checks++;
      if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_pop_valid: got %b expected 0", bus.pop_valid); end
      checks++;
      if (bus.pop_data !== 16'h0) begin failures++; $display("FAIL rst_mid_pop_data: got %h expected 0000", bus.pop_data); end
      checks++;
      if (underrun !== 1'b0) begin failures++; $display("FAIL rst_mid_underrun: got %b expected 0", underrun); end
      bus.video_next = 1'b0;
      bus.video_strobe = 1'b0;
      bus.pop_req = 1'b0;
      line_start = 1'b0;
      ret_q.delete();
      exp_q.delete();
      tb_cnt = 0;
      tb_infl = 0;
      pop_period = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      go_seen = 0;
      repeat (10) begin
         tick(1'b0, 1'b1);
         if (bus.video_go) go_seen++;
      end
      checks++;
      if (go_seen != 0) begin failures++; $display("FAIL rst_no_go: got %0d go cycles expected 0", go_seen); end
      fetch_words = 7'd2;
      pop_period = 1;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (bus.video_go !== 1'b1) begin failures++; $display("FAIL rst_restart_go: got %b expected 1", bus.video_go); end
      for (int i = 0; i < 40 && npop < 2; i++) tick(1'b0, 1'b1);
      checks++;
      if (npop != 2) begin failures++; $display("FAIL rst_restart_pops: got %0d expected 2", npop); end
      gnt_period = 0;
      pop_period = 0;
      repeat (4) tick(1'b0, 1'b1);
   endtask

`ifdef VIDEO_FETCH_STATS_EN
   task automatic test_stats();
      fetch_words = 7'd0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL stats_frame_start: got %0d expected 0", underrun_cnt); end
      repeat (5) begin
         pop_force = 1'b1;
         tick(1'b0, 1'b1);
         pop_force = 1'b0;
         tick(1'b0, 1'b1);
      end
      tick(1'b0, 1'b1);
      checks++;
      if (underrun_cnt !== 8'd5) begin failures++; $display("FAIL stats_count: got %0d expected 5", underrun_cnt); end
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (underrun_cnt !== 8'd5) begin failures++; $display("FAIL stats_mid_frame: got %0d expected 5", underrun_cnt); end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      checks++;
      if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL stats_next_frame: got %0d expected 0", underrun_cnt); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      line_start = 1'b0;
      vpix = 1'b0;
      fetch_words = '0;
      bus.video_next = 1'b0;
      bus.video_strobe = 1'b0;
      bus.video_data = '0;
      bus.pop_req = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_underrun();
      test_reset_mid();
`ifdef VIDEO_FETCH_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
